// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one valid/ready request, WAIT_CYCLES wait states, one valid/ready response.
// Define DM_RESP_ALIGN_CHECK_EN to flag misaligned addresses with rsp_err instead of accessing storage.
module dm_responder #(
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  stateT                 state;
  stateT                 nextState;
  logic [3:0]            waitCnt;
  logic                  capWe;
  logic [DEPTH_LOG2-1:0] capIdx;
  logic [1:0]            capOffset;
  logic [WORD_WIDTH-1:0] capWdata;
  logic                  accept;
  logic                  access;
  logic                  misaligned;
  logic                  unusedAddrBits;

  logic [WORD_WIDTH-1:0] storage [2**DEPTH_LOG2];

`ifdef DM_RESP_ALIGN_CHECK_EN
  assign misaligned     = (capOffset != 2'b00);
  assign unusedAddrBits = ^req_addr[31:DEPTH_LOG2+2];
`else
  assign misaligned     = 1'b0;
  assign unusedAddrBits = ^{req_addr[31:DEPTH_LOG2+2], capOffset};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Handshake outputs decode the registered state only, never req_valid.
  always_comb begin
    nextState = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (waitCnt == 4'd0) begin
          access    = 1'b1;
          nextState = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt   <= 4'd0;
      capWe     <= 1'b0;
      capIdx    <= '0;
      capOffset <= 2'b00;
      capWdata  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        capWe     <= req_we;
        capIdx    <= req_addr[DEPTH_LOG2+1:2];
        capOffset <= req_addr[1:0];
        capWdata  <= req_wdata;
        waitCnt   <= WaitLoad;
      end else if (state == WAIT && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end
      // Response registers stay untouched while in RESP, so they hold under backpressure.
      if (access) begin
        rsp_rdata <= (capWe || misaligned) ? '0 : storage[capIdx];
        rsp_err   <= misaligned;
      end
    end
  end

  // Storage has no reset; a write lands only on the access edge, so a reset during WAIT drops it.
  always_ff @(posedge clk) begin
    if (access && capWe && !misaligned) begin
      storage[capIdx] <= capWdata;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder acting as the CPU initiator, with a word-array reference model.
// Expectations follow DM_RESP_ALIGN_CHECK_EN when it is defined for the build.
module tb_dm_responder;

  localparam int WordWidth  = 32;
  localparam int DepthLog2  = 8;
  localparam int WaitCycles = 2;
  localparam int Words      = 1 << DepthLog2;
  localparam int TimeoutCycles = 40;

`ifdef DM_RESP_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [WordWidth-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WordWidth-1:0] rsp_rdata;
  logic                 rsp_err;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] model [Words];

  dm_responder #(
    .WORD_WIDTH (WordWidth),
    .DEPTH_LOG2 (DepthLog2),
    .WAIT_CYCLES(WaitCycles)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // One full transaction; idle junk is presented while req_ready is low to prove it is not captured.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold,
                               output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    checkOutput({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    rsp_ready = (hold == 0);
    checkOutput({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
    lat = 0;
    while (!rsp_valid && lat < TimeoutCycles) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " rsp_valid seen"}, 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, " hold rsp_rdata"}, rsp_rdata, rdata);
      checkOutput({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput({tag, " rsp_valid after hs"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, " req_ready after hs"}, 32'(req_ready), 32'd1);
  endtask

  task automatic doTxn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          idx;
    bit          mis;
    logic [31:0] expData;
    idx     = int'((addr / 4) % Words);
    mis     = AlignEn && ((addr % 4) != 0);
    expData = (we || mis) ? 32'd0 : model[idx];
    if (we && !mis) model[idx] = wdata;
    applyStimulus(tag, we, addr, wdata, hold, rdata, err, lat);
    checkOutput({tag, " rsp_rdata"}, rdata, expData);
    checkOutput({tag, " rsp_err"}, 32'(err), 32'(mis));
    checkOutput({tag, " latency"}, 32'(lat), 32'(WaitCycles + 1));
  endtask

  task automatic launchRequest(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitForResp(input string tag, input logic [31:0] expData);
    int n;
    n = 0;
    while (!rsp_valid && n < TimeoutCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, " rsp_rdata"}, rsp_rdata, expData);
  endtask

  // Reset is dropped mid-cycle and the outputs are sampled before any clock edge.
  task automatic pulseReset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    #2;
    checkOutput("por req_ready", 32'(req_ready), 32'd1);
    checkOutput("por rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("por rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("por rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < Words; i++) begin
      doTxn("prefill", 1'b1, 32'(i * 4), $urandom, 0);
    end

    doTxn("wr 0x10", 1'b1, 32'h10, 32'hDEADBEEF, 0);
    doTxn("rd 0x10", 1'b0, 32'h10, 32'h0, 0);
    doTxn("rd 0x10 backpressure", 1'b0, 32'h10, 32'h0, 3);

    doTxn("wr 0x400", 1'b1, 32'h400, 32'h12345678, 0);
    doTxn("rd 0x000 wrap", 1'b0, 32'h0, 32'h0, 0);

    launchRequest(1'b0, 32'h10, 32'h0);
    waitForResp("rd 0x10 to RESP", 32'hDEADBEEF);
    pulseReset("reset in read RESP");

    launchRequest(1'b1, 32'h30, 32'h5A5A0001);
    waitForResp("wr 0x30 to RESP", 32'h0);
    model[12] = 32'h5A5A0001;
    pulseReset("reset in write RESP");
    doTxn("rd 0x30 after RESP reset", 1'b0, 32'h30, 32'h0, 0);

    doTxn("wr 0x20 one", 1'b1, 32'h20, 32'h1, 0);
    launchRequest(1'b1, 32'h20, 32'hAAAA5555);
    pulseReset("reset in WAIT");
    doTxn("rd 0x20 after WAIT reset", 1'b0, 32'h20, 32'h0, 0);

    doTxn("rd 0x22 unaligned", 1'b0, 32'h22, 32'h0, 0);
    doTxn("wr 0x22 unaligned", 1'b1, 32'h22, 32'hCAFEF00D, 1);
    doTxn("rd 0x20 after unaligned wr", 1'b0, 32'h20, 32'h0, 0);
    doTxn("rd 0x23 unaligned", 1'b0, 32'h23, 32'h0, 2);

    for (int i = 0; i < 80; i++) begin
      doTxn("random", 1'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
